// File: rtl/y86_pkg.sv
// rtl/y86_pkg.sv - shared Y86-64 constants, memory-op decode and helpers
package y86_pkg;

    localparam logic [3:0] I_HALT   = 4'h0;
    localparam logic [3:0] I_NOP    = 4'h1;
    localparam logic [3:0] I_RRMOVQ = 4'h2;
    localparam logic [3:0] I_IRMOVQ = 4'h3;
    localparam logic [3:0] I_RMMOVQ = 4'h4;
    localparam logic [3:0] I_MRMOVQ = 4'h5;
    localparam logic [3:0] I_OPQ    = 4'h6;
    localparam logic [3:0] I_JXX    = 4'h7;
    localparam logic [3:0] I_CALL   = 4'h8;
    localparam logic [3:0] I_RET    = 4'h9;
    localparam logic [3:0] I_PUSHQ  = 4'hA;
    localparam logic [3:0] I_POPQ   = 4'hB;

    localparam logic [1:0] STAT_AOK = 2'd0;
    localparam logic [1:0] STAT_HLT = 2'd1;
    localparam logic [1:0] STAT_ADR = 2'd2;
    localparam logic [1:0] STAT_INS = 2'd3;

    localparam logic [3:0] RNONE = 4'hF;

    localparam int DMEM_BYTES = 1024;

    typedef enum logic [1:0] {
        MEM_NONE  = 2'd0,
        MEM_READ  = 2'd1,
        MEM_WRITE = 2'd2
    } mem_op_t;

    // Kind of data-memory access an instruction performs.
    function automatic mem_op_t decode_mem_op(input logic [3:0] icode);
        mem_op_t op;
        case (icode)
            I_MRMOVQ, I_POPQ, I_RET:  op = MEM_READ;
            I_RMMOVQ, I_PUSHQ, I_CALL: op = MEM_WRITE;
            default:                  op = MEM_NONE;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/data_mem.sv
// rtl/data_mem.sv - 1 KiB byte-addressed data memory, 8-byte little-endian ports
module data_mem
    import y86_pkg::*;
(
    input  logic        clk,
    input  logic        rd_en,
    input  logic        wr_en,
    input  logic        wr_commit,
    input  logic [63:0] addr,
    input  logic [63:0] wr_data,
    output logic [63:0] rd_data,
    output logic        dmem_error
);

    localparam logic [63:0] LAST_ADDR = 64'(DMEM_BYTES - 8);

    logic [7:0] mem_q [0:DMEM_BYTES-1];
    logic [9:0] base;

    assign base = addr[9:0];

    // Range check: negative (bit 63 set) or running past the last byte is an error.
    always_comb begin
        dmem_error = 1'b0;
        if (rd_en || wr_en) begin
            dmem_error = addr[63] || (addr > LAST_ADDR);
        end
    end

    // Combinational little-endian read; zero when not reading or out of range.
    always_comb begin
        rd_data = '0;
        if (rd_en && !dmem_error) begin
            for (int i = 0; i < 8; i++) begin
                rd_data[8*i +: 8] = mem_q[base + 10'(i)];
            end
        end
    end

    // Clocked 8-byte write; contents are never cleared by reset.
    always_ff @(posedge clk) begin
        if (wr_commit) begin
            for (int i = 0; i < 8; i++) begin
                mem_q[base + 10'(i)] <= wr_data[8*i +: 8];
            end
        end
    end

endmodule

// File: rtl/mem_stage.sv
// rtl/mem_stage.sv - Y86-64 memory stage: address decode, m_stat and W register
module mem_stage
    import y86_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic [1:0]         M_stat,
    input  logic [3:0]         M_icode,
    input  logic               M_Cnd,
    input  logic signed [63:0] M_valE,
    input  logic signed [63:0] M_valA,
    input  logic [3:0]         M_dstE,
    input  logic [3:0]         M_dstM,
    input  logic               W_stall,
    input  logic               W_bubble,
    output logic signed [63:0] m_valM,
    output logic [1:0]         m_stat,
    output logic [1:0]         W_stat,
    output logic [3:0]         W_icode,
    output logic signed [63:0] W_valE,
    output logic signed [63:0] W_valM,
    output logic [3:0]         W_dstE,
    output logic [3:0]         W_dstM
);

    mem_op_t     mem_op;
    logic [63:0] mem_addr;
    logic        rd_en;
    logic        wr_en;
    logic        wr_commit;
    logic        dmem_error;
    logic [63:0] rd_data;

    logic [1:0]  w_stat_q,  w_stat_d;
    logic [3:0]  w_icode_q, w_icode_d;
    logic [63:0] w_vale_q,  w_vale_d;
    logic [63:0] w_valm_q,  w_valm_d;
    logic [3:0]  w_dste_q,  w_dste_d;
    logic [3:0]  w_dstm_q,  w_dstm_d;

    // The branch condition only matters upstream; it has no memory effect here.
    logic unused_cnd;
    assign unused_cnd = M_Cnd;

    // Access kind and address: popq/ret address through valA, everything else through valE.
    always_comb begin
        mem_op   = decode_mem_op(M_icode);
        mem_addr = M_valE;
        if (M_icode == I_POPQ || M_icode == I_RET) begin
            mem_addr = M_valA;
        end
    end

    assign rd_en = (mem_op == MEM_READ);
    assign wr_en = (mem_op == MEM_WRITE);

    // A store only lands when this instruction and the one ahead of it in W are healthy.
    assign wr_commit = wr_en && !dmem_error && !reset
                       && (M_stat == STAT_AOK) && (w_stat_q == STAT_AOK);

    data_mem u_dmem (
        .clk        (clk),
        .rd_en      (rd_en),
        .wr_en      (wr_en),
        .wr_commit  (wr_commit),
        .addr       (mem_addr),
        .wr_data    (M_valA),
        .rd_data    (rd_data),
        .dmem_error (dmem_error)
    );

    assign m_valM = rd_data;
    assign m_stat = dmem_error ? STAT_ADR : M_stat;

    // W next state: stall holds everything, bubble injects a nop, otherwise load from M.
    always_comb begin
        w_stat_d  = w_stat_q;
        w_icode_d = w_icode_q;
        w_vale_d  = w_vale_q;
        w_valm_d  = w_valm_q;
        w_dste_d  = w_dste_q;
        w_dstm_d  = w_dstm_q;
        if (!W_stall) begin
            if (W_bubble) begin
                w_stat_d  = STAT_AOK;
                w_icode_d = I_NOP;
                w_vale_d  = '0;
                w_valm_d  = '0;
                w_dste_d  = RNONE;
                w_dstm_d  = RNONE;
            end else begin
                w_stat_d  = m_stat;
                w_icode_d = M_icode;
                w_vale_d  = M_valE;
                w_valm_d  = m_valM;
                w_dste_d  = M_dstE;
                w_dstm_d  = M_dstM;
            end
        end
    end

    // W register; reset outranks stall.
    always_ff @(posedge clk) begin
        if (reset) begin
            w_stat_q  <= STAT_AOK;
            w_icode_q <= I_NOP;
            w_vale_q  <= '0;
            w_valm_q  <= '0;
            w_dste_q  <= RNONE;
            w_dstm_q  <= RNONE;
        end else begin
            w_stat_q  <= w_stat_d;
            w_icode_q <= w_icode_d;
            w_vale_q  <= w_vale_d;
            w_valm_q  <= w_valm_d;
            w_dste_q  <= w_dste_d;
            w_dstm_q  <= w_dstm_d;
        end
    end

    assign W_stat  = w_stat_q;
    assign W_icode = w_icode_q;
    assign W_valE  = w_vale_q;
    assign W_valM  = w_valm_q;
    assign W_dstE  = w_dste_q;
    assign W_dstM  = w_dstm_q;

endmodule

// File: tb/tb_mem_stage.sv
// tb/tb_mem_stage.sv - scoreboard bench for mem_stage with a behavioural model
module tb_mem_stage;

    logic               clk = 1'b0;
    logic               reset;
    logic [1:0]         M_stat;
    logic [3:0]         M_icode;
    logic               M_Cnd;
    logic signed [63:0] M_valE;
    logic signed [63:0] M_valA;
    logic [3:0]         M_dstE;
    logic [3:0]         M_dstM;
    logic               W_stall;
    logic               W_bubble;
    logic signed [63:0] m_valM;
    logic [1:0]         m_stat;
    logic [1:0]         W_stat;
    logic [3:0]         W_icode;
    logic signed [63:0] W_valE;
    logic signed [63:0] W_valM;
    logic [3:0]         W_dstE;
    logic [3:0]         W_dstM;

    mem_stage dut (
        .clk(clk), .reset(reset), .M_stat(M_stat), .M_icode(M_icode), .M_Cnd(M_Cnd),
        .M_valE(M_valE), .M_valA(M_valA), .M_dstE(M_dstE), .M_dstM(M_dstM),
        .W_stall(W_stall), .W_bubble(W_bubble), .m_valM(m_valM), .m_stat(m_stat),
        .W_stat(W_stat), .W_icode(W_icode), .W_valE(W_valE), .W_valM(W_valM),
        .W_dstE(W_dstE), .W_dstM(W_dstM)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  stat;
        logic [3:0]  icode;
        logic [63:0] vale;
        logic [63:0] valm;
        logic [3:0]  dste;
        logic [3:0]  dstm;
    } w_t;

    typedef struct {
        logic [63:0] valm;
        logic [1:0]  mstat;
        w_t          w;
    } exp_t;

    exp_t       exp_q[$];
    logic [7:0] mdl_mem [0:1023];
    w_t         mdl_w;
    int         n_checks = 0;
    int         n_err = 0;

    function automatic w_t w_reset_val();
        w_t r;
        r.stat = 2'd0; r.icode = 4'h1; r.vale = '0; r.valm = '0; r.dste = 4'hF; r.dstm = 4'hF;
        return r;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Issue one M-stage instruction for one cycle; the model predicts this cycle's outputs.
    task automatic apply(input bit rst, input logic [1:0] st, input logic [3:0] ic,
                         input logic [63:0] ve, input logic [63:0] va,
                         input logic [3:0] de, input logic [3:0] dm,
                         input bit stl, input bit bub);
        longint      a;
        bit          is_rd, is_wr, err;
        logic [63:0] rv;
        logic [1:0]  ms;
        exp_t        e;
        reset = rst; M_stat = st; M_icode = ic; M_Cnd = $urandom_range(0, 1);
        M_valE = ve; M_valA = va; M_dstE = de; M_dstM = dm; W_stall = stl; W_bubble = bub;
        is_rd = 0; is_wr = 0; a = 0;
        if (ic == 4'h5)                  begin is_rd = 1; a = ve; end
        if (ic == 4'h9 || ic == 4'hB)    begin is_rd = 1; a = va; end
        if (ic == 4'h4 || ic == 4'hA || ic == 4'h8) begin is_wr = 1; a = ve; end
        err = (is_rd || is_wr) && (a < 0 || a > 1023 - 7);
        rv = 0;
        if (is_rd && !err)
            for (int k = 0; k < 8; k++) rv = rv | (64'(mdl_mem[a + k]) << (8 * k));
        ms = err ? 2'd2 : st;
        e.valm = rv; e.mstat = ms; e.w = mdl_w;
        exp_q.push_back(e);
        if (is_wr && !err && st == 2'd0 && !rst && mdl_w.stat == 2'd0)
            for (int k = 0; k < 8; k++) mdl_mem[a + k] = va[8*k +: 8];
        if (rst) mdl_w = w_reset_val();
        else if (stl) mdl_w = mdl_w;
        else if (bub) mdl_w = w_reset_val();
        else begin
            mdl_w.stat = ms; mdl_w.icode = ic; mdl_w.vale = ve; mdl_w.valm = rv;
            mdl_w.dste = de; mdl_w.dstm = dm;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic op(input logic [3:0] ic, input logic [63:0] ve, input logic [63:0] va);
        apply(0, 2'd0, ic, ve, va, 4'h3, 4'h7, 0, 0);
    endtask

    // Monitor: every cycle's outputs are compared with the oldest prediction.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            chk("m_valM",  m_valM,  e.valm);
            chk("m_stat",  64'(m_stat),  64'(e.mstat));
            chk("W_stat",  64'(W_stat),  64'(e.w.stat));
            chk("W_icode", 64'(W_icode), 64'(e.w.icode));
            chk("W_valE",  W_valE,  e.w.vale);
            chk("W_valM",  W_valM,  e.w.valm);
            chk("W_dstE",  64'(W_dstE),  64'(e.w.dste));
            chk("W_dstM",  64'(W_dstM),  64'(e.w.dstm));
        end
    end

    function automatic logic [63:0] rand_addr();
        logic [63:0] edges [6];
        edges[0] = -64'sd8; edges[1] = 64'd1016; edges[2] = 64'd1017;
        edges[3] = 64'd1023; edges[4] = -64'sd1; edges[5] = 64'h8000_0000_0000_0000;
        if ($urandom_range(0, 5) == 0) return edges[$urandom_range(0, 5)];
        return 64'($urandom_range(0, 128));
    endfunction

    initial begin
        logic [63:0] r;
        reset = 1; M_stat = 0; M_icode = 4'h1; M_Cnd = 0; M_valE = 0; M_valA = 0;
        M_dstE = 4'hF; M_dstM = 4'hF; W_stall = 0; W_bubble = 0;
        repeat (2) @(posedge clk);
        #1;
        mdl_w = w_reset_val();

        // Fill the region the bench reads from so every read has a known value.
        for (int k = 0; k <= 16; k++) op(4'h4, 64'(k * 8), {$urandom, $urandom});
        op(4'h4, 64'd1016, {$urandom, $urandom});

        // Store then load at 16.
        op(4'h4, 64'd16, 64'h1122_3344_5566_7788);
        op(4'h5, 64'd16, 64'd0);
        chk("byte16", 64'(dut.u_dmem.mem_q[16]), 64'h88);

        // Range boundary.
        op(4'h5, 64'd1017, 64'd0);
        op(4'h1, 64'd0, 64'd0);
        op(4'h5, 64'd1016, 64'd0);

        // Negative address, then a halted W blocks the next store.
        op(4'hA, -64'sd8, 64'hDEAD_BEEF);
        apply(0, 2'd1, 4'h0, 0, 0, 4'hF, 4'hF, 0, 0);
        r = 64'hCAFE_F00D_0BAD_BEEF;
        op(4'h4, 64'd0, r);
        chk("byte0", 64'(dut.u_dmem.mem_q[0]), 64'(mdl_mem[0]));
        op(4'h5, 64'd0, 64'd0);

        // Stall, stall+bubble, bubble.
        apply(0, 2'd0, 4'h6, 64'd5, 64'd9, 4'h3, 4'hF, 0, 0);
        apply(0, 2'd0, 4'h2, 64'd77, 64'd1, 4'h5, 4'h6, 1, 0);
        apply(0, 2'd0, 4'h3, 64'd88, 64'd2, 4'h8, 4'h9, 1, 0);
        apply(0, 2'd0, 4'h6, 64'd99, 64'd3, 4'hA, 4'hB, 1, 1);
        apply(0, 2'd0, 4'h6, 64'd11, 64'd4, 4'h2, 4'h2, 0, 1);
        op(4'h1, 64'd0, 64'd0);

        // Reset during stall with a concurrent store.
        apply(0, 2'd0, 4'h6, 64'd12, 64'd0, 4'h1, 4'hF, 1, 0);
        apply(1, 2'd0, 4'h4, 64'd32, 64'h5555_AAAA_5555_AAAA, 4'hF, 4'hF, 1, 0);
        chk("byte32", 64'(dut.u_dmem.mem_q[32]), 64'(mdl_mem[32]));
        op(4'h5, 64'd32, 64'd0);

        // call then popq through the same slot.
        op(4'h8, 64'd40, 64'h100);
        op(4'hB, 64'd48, 64'd40);
        op(4'h1, 64'd0, 64'd0);

        // Randomized traffic.
        for (int n = 0; n < 400; n++) begin
            logic [1:0] st;
            st = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(0, 3)) : 2'd0;
            apply($urandom_range(0, 39) == 0, st, 4'($urandom_range(0, 11)),
                  rand_addr(), ($urandom_range(0, 1) == 1) ? rand_addr() : {$urandom, $urandom},
                  4'($urandom), 4'($urandom),
                  $urandom_range(0, 5) == 0, $urandom_range(0, 5) == 0);
        end

        op(4'h1, 64'd0, 64'd0);
        repeat (3) @(posedge clk);
        chk("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/mem_stage.md
MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 clk  input  1  single clock; all state updates on posedge clk.
REQ-002 reset  input  1  synchronous, active-high reset, sampled on posedge clk.
REQ-003 M_stat  input  2  status from M pipeline register.
REQ-004 M_icode  input  4  instruction code from M register.
REQ-005 M_Cnd  input  1  condition flag from M register; carried for control, no memory effect.
REQ-006 M_valE  input  64 signed  ALU result: address for rmmovq/mrmovq/pushq/call; writeback value.
REQ-007 M_valA  input  64 signed  store data for rmmovq/pushq/call; address for popq/ret.
REQ-008 M_dstE, M_dstM  input  4 each  destination register IDs.
REQ-009 W_stall  input  1  hold W register contents.
REQ-010 W_bubble  input  1  load nop into W register.
REQ-011 m_valM  output  64 signed  combinational read data, for forwarding.
REQ-012 m_stat  output  2  combinational stage status, for pipeline control.
REQ-013 W_stat, W_icode, W_valE, W_valM, W_dstE, W_dstM  output  2/4/64/64/4/4  registered W pipeline register.

Function
REQ-014 Data memory: 1024 bytes, byte-addressed; 8-byte accesses, little-endian.
REQ-015 Read icodes: mrmovq (5) addr=M_valE; popq (B) and ret (9) addr=M_valA.
REQ-016 Write icodes: rmmovq (4), pushq (A), call (8); addr=M_valE, data=M_valA.
REQ-017 All other icodes: no memory access; m_valM=0.
REQ-018 dmem_error when an access occurs and (addr<0 or addr+7>1023); addr is treated as signed 64-bit; addr=1016 is valid, addr=1017 is an error.
REQ-019 Read data is combinational from the array; m_valM=0 on dmem_error.
REQ-020 Write commits at posedge clk only if M_stat=AOK, no dmem_error, reset=0, and W_stat=AOK; otherwise the array is unchanged.
REQ-021 m_stat = ADR if dmem_error, else M_stat.
REQ-022 W update priority per posedge: reset > W_stall (hold all W fields) > W_bubble (nop load) > normal load.
REQ-023 Normal load: W_stat<=m_stat, W_icode<=M_icode, W_valE<=M_valE, W_valM<=m_valM, W_dstE<=M_dstE, W_dstM<=M_dstM.
REQ-024 Bubble load: W_icode<=NOP(1), W_stat<=AOK, W_dstE=W_dstM<=RNONE(F), W_valE=W_valM<=0.
REQ-025 W_stall and W_bubble both high: stall wins; W holds.
REQ-026 Read and write to the same bytes in one cycle cannot occur (one access per instruction); a read in the cycle after a write returns the new data.
REQ-027 Latency: m_valM/m_stat are valid in the same cycle as the inputs; W fields are valid one cycle later.

Reset
REQ-028 reset high at posedge: W_stat=AOK, W_icode=NOP, W_valE=W_valM=0, W_dstE=W_dstM=RNONE.
REQ-029 reset blocks any pending memory write in that cycle; array contents are otherwise preserved (not cleared).
REQ-030 Reset mid-stall: reset overrides W_stall.

Structure
REQ-031 Shared package y86_pkg: icode constants (HALT 0 ... POPQ B), stat encodings AOK=0, HLT=1, ADR=2, INS=3, RNONE=4'hF, DMEM_BYTES=1024.
REQ-032 Sub-module data_mem: byte array, combinational 8-byte read, clocked 8-byte write enable, range check producing dmem_error.
REQ-033 mem_stage contains the address/op decode, m_stat logic, and the W register.

Verification
REQ-034 rmmovq icode=4, valE=16, valA=0x1122334455667788, AOK; next cycle mrmovq valE=16 -> m_valM=0x1122334455667788, byte 16=0x88.
REQ-035 mrmovq valE=1017 -> m_stat=ADR, m_valM=0; next cycle W_stat=ADR; valE=1016 -> m_stat=AOK.
REQ-036 pushq valE=-8 -> ADR and no write; W_stat=HLT, then rmmovq valE=0 -> memory byte 0 unchanged.
REQ-037 W loaded with OPq valE=5 dstE=3, then W_stall=1 for 2 cycles with new inputs -> W unchanged; W_stall=W_bubble=1 -> hold; W_bubble only -> W_icode=1, W_dstE=F.
REQ-038 reset asserted during stall, with a concurrent rmmovq valE=32 -> W at reset values; byte 32 unchanged.
REQ-039 popq valA=40 after call valE=40 valA=0x100 -> m_valM=0x100, W_valM=0x100 next cycle.
